match_sequencer: RTL
====================

# match_sequencer

Top-level game-flow controller for the pong datapath. Sequences attract, serve delay, rally, point pause and game-over phases. Gates the ball mover, issues serve pulses with direction, keeps both players' scores and drives the sound request. Sits between the debounced buttons, frame timing, ball/paddle logic, score renderer and sound generator.

## Interface
- `WIN_SCORE`, 4'd9: score that ends the match; 1..15.
- `SERVE_FRAMES`, 8'd60: frame ticks spent in SERVE_WAIT; 1..255.
- `POINT_FRAMES`, 8'd30: frame ticks spent in POINT; 1..255.
- `SOUND_FRAMES`, 8'd8: frame ticks `sound` is held after a point; 1..255.
- `clk` in 1: system clock; one clock only.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per video frame (start of vsync).
- `start` in 1: one-cycle debounced start/restart pulse.
- `miss_left` in 1: one-cycle pulse; ball passed player A (left). Point to B.
- `miss_right` in 1: one-cycle pulse; ball passed player B (right). Point to A.
- `paddle_hit` in 1: one-cycle pulse; ball deflected by a paddle.
- `state` out 3: 0 ATTRACT, 1 SERVE_WAIT, 2 RALLY, 3 POINT, 4 GAME_OVER.
- `ball_run` out 1: ball mover enable; high only in RALLY.
- `serve` out 1: one-cycle pulse; ball mover reloads centre position.
- `serve_dir` out 1: 1 = ball travels right (toward B), 0 = left. Valid while `serve` is high; held otherwise.
- `score_a`, `score_b` out 4 each: binary scores.
- `game_over` out 1: high in GAME_OVER.
- `sound` out 1: sound generator enable.

## Operation
- All state is in registers clocked on the posedge of `clk`, with async clear on `reset_n` low.
- Reset values:
  - `state`=ATTRACT, scores 0, `serve`=0, `serve_dir`=1.
  - `sound`=0, frame counter 0, sound counter 0.
  - `ball_run`=0, `game_over`=0.
- `ball_run` and `game_over` are decoded from `state`.
- ATTRACT: `start` -> scores cleared, `serve_dir`<=1, frame counter<=SERVE_FRAMES, go to SERVE_WAIT.
- SERVE_WAIT: each `frame_tick` decrements the frame counter.
  - On a `frame_tick` with counter==1 -> go to RALLY and assert `serve` for exactly the first RALLY cycle.
- RALLY:
  - `miss_left` -> `score_b`+1, `serve_dir`<=0 (next serve toward the loser, A).
  - `miss_right` -> `score_a`+1, `serve_dir`<=1.
  - On either miss: frame counter<=POINT_FRAMES, sound counter<=SOUND_FRAMES, go to POINT.
  - Both misses in one cycle: `miss_left` wins; only B scores.
- POINT: `frame_tick` decrements the frame counter. On a tick with counter==1:
  - If `score_a`==WIN_SCORE or `score_b`==WIN_SCORE -> GAME_OVER.
  - Otherwise frame counter<=SERVE_FRAMES and go to SERVE_WAIT.
- GAME_OVER: scores frozen. `start` behaves exactly as in ATTRACT.
- `start` in SERVE_WAIT, RALLY or POINT restarts the match, identical to the ATTRACT action. `start` has priority over a same-cycle miss or terminal tick.
- `miss_*` pulses outside RALLY are ignored. `paddle_hit` is ignored outside RALLY.
- Scores cannot exceed WIN_SCORE. No wrap logic is needed, but the increment is 4-bit.
- Sound:
  - `sound` = (sound counter != 0).
  - `frame_tick` decrements a nonzero sound counter.
  - `paddle_hit` in RALLY loads 1 if the counter is 0; it never shortens a running point sound.
  - A point load overrides a concurrent hit.
  - `start` clears the sound counter.

## Timing
- Every input pulse is acted on at the clock edge where it is sampled high. Outputs change one cycle after that edge.
- SERVE_WAIT -> RALLY latency: exactly SERVE_FRAMES `frame_tick` pulses after entry. A `frame_tick` in the same cycle as entry is not counted.
- `serve` is one cycle wide, registered and coincident with the first cycle of `state`==RALLY.
- A miss moves `state` and the score on the same edge. `sound` rises one cycle after the miss.
- `frame_tick` and `start` in the same cycle: `start` wins and the counter reloads.
- `reset_n` low at any time forces all reset values immediately, regardless of `clk`. Release is synchronous to the next posedge.

## Test plan
Parameters for all scenarios: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=2, SOUND_FRAMES=3.

1. Reset, then `start`:
   - `state`=1.
   - After 2 `frame_tick`: `state`=2, `serve`=1 for one cycle, `serve_dir`=1, `ball_run`=1.
2. In RALLY pulse `miss_right`:
   - `score_a`=1, `state`=3, `sound`=1 for 3 frame ticks.
   - After 2 ticks: `state`=1.
   - Next serve has `serve_dir`=1.
   - Repeat with `miss_left`: `score_b`=1, `serve_dir`=0.
3. `miss_left` and `miss_right` in the same cycle: only `score_b` increments, `serve_dir`=0.
4. Three `miss_right` points:
   - After the POINT pause: `state`=4, `game_over`=1, `score_a`=3.
   - Later `miss_*` pulses change nothing.
   - `start` -> scores 0, `state`=1.
5. `start` mid-RALLY with `score_a`=2:
   - Scores 0, `sound`=0, `state`=1, `ball_run`=0.
   - `miss_*` pulses in ATTRACT, SERVE_WAIT and POINT are ignored.
6. `reset_n` asserted mid-POINT, asynchronously between clock edges: outputs go to reset values at once. `paddle_hit` in RALLY gives `sound` high for exactly 1 frame tick.

Source files
------------

// File: rtl/match_sequencer.sv
// ---------------------------------------------------------------------------
// match_sequencer: pong game-flow controller (attract/serve/rally/point/over),
// scores, serve pulses and sound request.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module match_sequencer #(
  parameter logic [3:0] WIN_SCORE    = 4'd9,
  parameter logic [7:0] SERVE_FRAMES = 8'd60,
  parameter logic [7:0] POINT_FRAMES = 8'd30,
  parameter logic [7:0] SOUND_FRAMES = 8'd8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       paddle_hit,
  output logic [2:0] state,
  output logic       ball_run,
  output logic       serve,
  output logic       serve_dir,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic       game_over,
  output logic       sound
);

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_RALLY      = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] score_a_q, score_a_d;
  logic [3:0] score_b_q, score_b_d;
  logic       serve_q, serve_d;
  logic       serve_dir_q, serve_dir_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] sound_cnt_q, sound_cnt_d;

  always_comb begin
    state_d     = state_q;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    serve_d     = 1'b0;
    serve_dir_d = serve_dir_q;
    frame_cnt_d = frame_cnt_q;
    sound_cnt_d = sound_cnt_q;

    if (frame_tick && (sound_cnt_q != 8'd0))
      sound_cnt_d = sound_cnt_q - 8'd1;
    if (paddle_hit && (state_q == ST_RALLY) && (sound_cnt_q == 8'd0))
      sound_cnt_d = 8'd1;

    // Restart takes priority over every same-cycle event in any state.
    if (start) begin
      state_d     = ST_SERVE_WAIT;
      score_a_d   = 4'd0;
      score_b_d   = 4'd0;
      serve_dir_d = 1'b1;
      frame_cnt_d = SERVE_FRAMES;
      sound_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_SERVE_WAIT: begin
          if (frame_tick) begin
            frame_cnt_d = frame_cnt_q - 8'd1;
            if (frame_cnt_q == 8'd1) begin
              state_d = ST_RALLY;
              serve_d = 1'b1;
            end
          end
        end
        ST_RALLY: begin
          if (miss_left || miss_right) begin
            if (miss_left) begin
              score_b_d   = score_b_q + 4'd1;
              serve_dir_d = 1'b0;
            end else begin
              score_a_d   = score_a_q + 4'd1;
              serve_dir_d = 1'b1;
            end
            frame_cnt_d = POINT_FRAMES;
            sound_cnt_d = SOUND_FRAMES;
            state_d     = ST_POINT;
          end
        end
        ST_POINT: begin
          if (frame_tick) begin
            frame_cnt_d = frame_cnt_q - 8'd1;
            if (frame_cnt_q == 8'd1) begin
              if ((score_a_q == WIN_SCORE) || (score_b_q == WIN_SCORE)) begin
                state_d = ST_GAME_OVER;
              end else begin
                frame_cnt_d = SERVE_FRAMES;
                state_d     = ST_SERVE_WAIT;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ATTRACT;
      score_a_q   <= 4'd0;
      score_b_q   <= 4'd0;
      serve_q     <= 1'b0;
      serve_dir_q <= 1'b1;
      frame_cnt_q <= 8'd0;
      sound_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      serve_q     <= serve_d;
      serve_dir_q <= serve_dir_d;
      frame_cnt_q <= frame_cnt_d;
      sound_cnt_q <= sound_cnt_d;
    end
  end

  assign state     = state_q;
  assign ball_run  = (state_q == ST_RALLY);
  assign game_over = (state_q == ST_GAME_OVER);
  assign serve     = serve_q;
  assign serve_dir = serve_dir_q;
  assign score_a   = score_a_q;
  assign score_b   = score_b_q;
  assign sound     = (sound_cnt_q != 8'd0);

endmodule

`default_nettype wire
